// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// BOOT/RUN/HALT controller that stops fetching at the end of instruction memory.
module if_stage #(
    parameter int unsigned START_PC   = 100,
    parameter int unsigned IMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'(START_PC);
    localparam logic [31:0] LAST_PC  = 32'(IMEM_BYTES - 4);

    state_t      state, state_nx;
    logic [31:0] pc_reg, pc_nx;
    logic [31:0] instr_nx, idpc_nx, idpc4_nx;
    logic        valid_nx, fault_nx;
    logic [31:0] pc_plus4;
    logic        pc_oob;

    assign pc_plus4  = pc_reg + 32'd4;
    assign pc_oob    = pc_reg > LAST_PC;
    assign imem_pc   = pc_reg;
    assign dbg_state = state;

    // IF/ID handshake: if_id_valid qualifies if_id_*; stall is ID's "not ready",
    // so the register holds while stall=1 and advances only when stall=0.
    // Priority: redirect > out-of-range > flush > stall > advance.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_reg;
        instr_nx = if_id_instr;
        idpc_nx  = if_id_pc;
        idpc4_nx = if_id_pc4;
        valid_nx = if_id_valid;
        fault_nx = fetch_fault;
        if (redirect_valid) begin
            pc_nx    = {redirect_pc[31:2], 2'b00};
            instr_nx = 32'd0;
            valid_nx = 1'b0;
            fault_nx = 1'b0;
            state_nx = RUN;
        end else begin
            case (state)
                BOOT: state_nx = RUN;
                RUN: begin
                    if (pc_oob) begin
                        instr_nx = 32'd0;
                        valid_nx = 1'b0;
                        fault_nx = 1'b1;
                        state_nx = HALT;
                    end else if (flush) begin
                        instr_nx = 32'd0;
                        valid_nx = 1'b0;
                        if (!stall) pc_nx = pc_plus4;
                    end else if (!stall) begin
                        instr_nx = imem_instr;
                        idpc_nx  = pc_reg;
                        idpc4_nx = pc_plus4;
                        valid_nx = 1'b1;
                        pc_nx    = pc_plus4;
                    end
                end
                HALT: valid_nx = 1'b0;
                default: state_nx = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_reg      <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            pc_reg      <= pc_nx;
            if_id_instr <= instr_nx;
            if_id_pc    <= idpc_nx;
            if_id_pc4   <= idpc4_nx;
            if_id_valid <= valid_nx;
            fetch_fault <= fault_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios then random stall/flush/redirect
// traffic, checked against a cycle-level behavioural model of the fetch rules.
module tb_if_stage;
    localparam int unsigned START_PC   = 100;
    localparam int unsigned IMEM_BYTES = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_pc, if_id_instr, if_id_pc, if_id_pc4;
    logic        if_id_valid, fetch_fault;
    logic [1:0]  dbg_state;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imem_pc;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_valid, m_fault, m_boot, m_halt;

    if_stage #(.START_PC(START_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .imem_instr(imem_instr), .stall(stall),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_pc(imem_pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_fault(fetch_fault),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Instruction memory contents, one distinct word per address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a >= 32'd100 && a <= 32'd128) return 32'h48080000 + ((a - 32'd100) >> 2) * 32'h00010004;
        if (a == 32'd500 || a == 32'd600) return 32'h2413000f;
        return 32'hc3000000 ^ a;
    endfunction

    assign imem_instr = word_at(imem_pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = START_PC; m_instr = 0; m_idpc = 0; m_idpc4 = 0;
        m_valid = 0; m_fault = 0; m_boot = 1; m_halt = 0;
    endtask

    // Effect of one clock edge given the inputs applied before it.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic st, input logic fl);
        if (rv) begin
            m_pc = rpc & 32'hffff_fffc;
            m_instr = 0; m_valid = 0; m_fault = 0; m_halt = 0; m_boot = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            m_valid = 0;
        end else if (m_pc > IMEM_BYTES - 4) begin
            m_instr = 0; m_valid = 0; m_fault = 1; m_halt = 1;
        end else if (fl) begin
            m_instr = 0; m_valid = 0;
            if (!st) m_pc = m_pc + 4;
        end else if (!st) begin
            m_instr = word_at(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic st, input logic fl);
        exp_t e;
        redirect_valid = rv; redirect_pc = rpc; stall = st; flush = fl;
        model_step(rv, rpc, st, fl);
        e.instr = m_instr; e.pc = m_idpc; e.pc4 = m_idpc4; e.imem_pc = m_pc;
        e.valid = m_valid; e.fault = m_fault;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic st, input logic fl);
        @(negedge clk);
        drive(rv, rpc, st, fl);
    endtask

    task automatic check_reset_values();
        check("rst_imem_pc", imem_pc, START_PC);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_pc4", if_id_pc4, 32'd0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    endtask

    // Asserts reset between edges, checks outputs before any edge, releases into BOOT.
    task automatic do_reset(input logic st);
        @(negedge clk);
        redirect_valid = 0; flush = 0; stall = st;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, st, 1'b0);
    endtask

    // Monitor: after each edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_pc", imem_pc, e.imem_pc);
                check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                check("if_id_instr", if_id_instr, e.instr);
                check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
                if (e.valid) begin
                    check("if_id_pc", if_id_pc, e.pc);
                    check("if_id_pc4", if_id_pc4, e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rv, st, fl;
        logic [31:0] rpc;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);                 // BOOT edge: nothing changes
        cycle(0, 0, 0, 0);                              // captures 100
        cycle(0, 0, 0, 0);                              // captures 104
        repeat (3) cycle(0, 0, 1, 0);                   // stall holds
        cycle(0, 0, 0, 0);                              // captures 108
        cycle(1, 32'h1f6, 1, 0);                        // redirect overrides stall
        cycle(0, 0, 0, 0);                              // captures 500
        cycle(1, 32'd204, 0, 1);                        // redirect overrides flush
        cycle(0, 0, 0, 1);                              // flush at 204
        cycle(0, 0, 0, 0);
        cycle(1, 32'd16380, 0, 0);
        cycle(0, 0, 0, 0);                              // last valid word
        cycle(0, 0, 0, 0);                              // 16384 faults
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 32'd600, 0, 0);                        // leaves HALT
        cycle(0, 0, 0, 0);
        cycle(1, 32'd16385, 0, 0);                      // out-of-range target
        cycle(0, 0, 0, 0);                              // re-fault
        cycle(0, 0, 0, 0);
        do_reset(1'b0);                                 // reset mid-HALT
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: rpc = $urandom();
                1: rpc = 32'd16360 + $urandom_range(0, 40);
                default: rpc = $urandom_range(0, IMEM_BYTES + 8);
            endcase
            cycle(rv, rpc, st, fl);
        end
        cycle(1, 32'd300, 0, 0);
        cycle(0, 0, 0, 0);
        do_reset(1'b1);                                 // reset mid-stall
        repeat (4) cycle(0, 0, 0, 0);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter START_PC, default 100, giving the reset fetch address in bytes.
REQ-003 The block SHALL have parameter IMEM_BYTES, default 16384, giving the instruction memory size in bytes.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_instr  input  32  big-endian word returned by the instruction memory for imem_pc, combinational within the same cycle.
REQ-007 stall  input  1  hazard stall from ID; holds PC and the IF/ID register.
REQ-008 flush  input  1  squashes the instruction being captured into IF/ID.
REQ-009 redirect_valid  input  1  taken branch, jump or jr resolved downstream.
REQ-010 redirect_pc  input  32  byte target address for the redirect.
REQ-011 imem_pc  output  32  fetch address driven to the instruction memory.
REQ-012 if_id_instr  output  32  registered instruction.
REQ-013 if_id_pc  output  32  registered address of if_id_instr.
REQ-014 if_id_pc4  output  32  registered if_id_pc+4.
REQ-015 if_id_valid  output  1  if_id_* holds a real instruction.
REQ-016 fetch_fault  output  1  sticky out-of-range fetch flag.

Function
REQ-017 imem_pc SHALL equal the internal pc_reg directly, with no combinational path from any input.
REQ-018 The FSM SHALL have states BOOT, RUN and HALT; reset SHALL enter BOOT.
REQ-019 BOOT SHALL last exactly one cycle after rst_n deasserts, capture nothing, hold pc_reg, then enter RUN.
REQ-020 RUN with redirect_valid=0 and stall=0 SHALL load IF/ID with {imem_instr, pc_reg, pc_reg+4, valid=1} and set pc_reg to pc_reg+4 (32-bit add, modulo 2^32).
REQ-021 RUN with stall=1 and redirect_valid=0 SHALL hold pc_reg and all IF/ID fields unchanged.
REQ-022 A redirect SHALL set pc_reg to {redirect_pc[31:2],2'b00} (low bits ignored) and load IF/ID as a bubble (instr=0, valid=0) in any state, overriding stall and flush.
REQ-023 flush=1 with redirect_valid=0 SHALL load a bubble into IF/ID; pc_reg SHALL advance by 4 if stall=0 and hold if stall=1.
REQ-024 Out-of-range fetch: in RUN, if pc_reg > IMEM_BYTES-4, IF/ID SHALL load a bubble, pc_reg SHALL hold, fetch_fault SHALL be set, and the FSM SHALL enter HALT; this SHALL occur only when redirect_valid=0.
REQ-025 HALT SHALL keep if_id_valid=0, hold pc_reg and ignore stall and flush.
REQ-026 A redirect SHALL exit HALT to RUN and clear fetch_fault; if the new pc_reg is also out of range, the next RUN cycle SHALL re-fault.
REQ-027 Redirect-to-fetch latency SHALL be one cycle: the target's instruction SHALL appear in IF/ID two edges after redirect_valid is sampled.
REQ-028 Event priority SHALL be: reset > redirect > out-of-range > flush > stall > normal advance.

Reset
REQ-029 Asserting rst_n low SHALL immediately set pc_reg=START_PC, if_id_instr=0, if_id_pc=0, if_id_pc4=0, if_id_valid=0, fetch_fault=0 and state=BOOT, including mid-stall and in HALT.
REQ-030 No output SHALL change on the first rising edge after rst_n deasserts other than the BOOT-to-RUN transition.

Verification
REQ-031 Reset release with instruction memory preloaded at 100..131: imem_pc=100; the first valid IF/ID is 0x48080000/pc 100/pc4 104 after the second edge; then 0x48090004 at 104, and so on.
REQ-032 stall held 3 cycles while if_id_pc=104: imem_pc stays 108 and IF/ID stays unchanged; on release, 108 (0x480a0008) is captured.
REQ-033 redirect_valid=1, redirect_pc=0x1F6 together with stall=1: pc_reg becomes 0x1F4 (500) and a bubble is loaded; next edge captures 0x2413000f with if_id_pc=500.
REQ-034 flush=1 for one cycle with pc_reg=204: if_id_valid=0 and instr=0; pc_reg becomes 208.
REQ-035 redirect to 16380 then run: 16380 is fetched validly; pc_reg=16384 raises fetch_fault and enters HALT with valid=0; redirect to 600 clears the fault and fetches 0x2413000f.
REQ-036 Assert rst_n low mid-HALT between edges: outputs return to reset values without a clock edge.
